// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue between the synchronous instruction ROM and ID.
// Fetches sequential PCs ahead of decode, stores {pc, instr} pairs in a small
// circular buffer and presents the oldest one over a valid/ready handshake.
// A flush from EX discards the queue and any in-flight ROM response and
// redirects fetch to the (word-aligned) branch target.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous reset, active-low
//   flush      branch taken in EX; redirect fetch
//   flush_pc   branch target from EX
//   im_addr    ROM address (current fetch PC)
//   im_req     a fetch issues at this clock edge
//   im_dout    ROM data, valid the cycle after the address
//   out_valid  queue head valid
//   out_ready  ID accepts the head
//   out_instr  head instruction (0 when empty)
//   out_pc     head PC (0 when empty)
//   count      current occupancy
module if_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [63:0]              flush_pc,
    output logic [63:0]              im_addr,
    output logic                     im_req,
    input  logic [31:0]              im_dout,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [63:0]              out_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t          mem_q [DEPTH];

    logic [63:0]     fetch_pc_q, fetch_pc_d;
    logic            pending_q,  pending_d;
    logic [63:0]     pend_pc_q,  pend_pc_d;
    logic [CW-1:0]   count_q,    count_d;
    logic [PW-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q,   rd_ptr_d;

    logic [CW:0]     occupancy;
    logic            push;
    logic            pop;
    entry_t          head;

    // Issue only when every queued and in-flight instruction has a slot;
    // a same-cycle pop is deliberately not credited.
    always_comb begin
        occupancy = {1'b0, count_q} + {{CW{1'b0}}, pending_q};
        im_req    = reset && !flush && (occupancy < (CW+1)'(DEPTH));
        push      = pending_q && !flush;
        pop       = out_valid && out_ready && !flush;
    end

    // Next-state: flush overrides issue, push and pop.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pending_d  = pending_q;
        pend_pc_d  = pend_pc_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (flush) begin
            fetch_pc_d = flush_pc & ~64'h3;
            pending_d  = 1'b0;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (im_req) begin
                pending_d  = 1'b1;
                pend_pc_d  = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + 64'd4;
            end else begin
                // Hold the address; the ROM re-reads it and the result is ignored.
                pending_d  = 1'b0;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            pending_q  <= 1'b0;
            pend_pc_q  <= 64'h0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pending_q  <= pending_d;
            pend_pc_q  <= pend_pc_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{pc: pend_pc_q, instr: im_dout};
        end
    end

    // Head presentation, forced to zero while empty.
    always_comb begin
        head      = mem_q[rd_ptr_q];
        out_valid = (count_q != '0);
        out_instr = out_valid ? head.instr : 32'h0;
        out_pc    = out_valid ? head.pc    : 64'h0;
        im_addr   = fetch_pc_q;
        count     = count_q;
    end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: synchronous ROM model, directed scenarios and a
// randomized phase. Expected delivery is the sequential PC stream starting at
// the last redirect target; a negedge monitor pops it on every handshake.
module tb_if_prefetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [63:0] flush_pc;
    logic [63:0] im_addr;
    logic        im_req;
    logic [31:0] im_dout;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic [2:0]  count;

    if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .flush_pc  (flush_pc),
        .im_addr   (im_addr),
        .im_req    (im_req),
        .im_dout   (im_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int pops   = 0;

    function automatic logic [31:0] rom_word(input logic [63:0] a);
        if (a == 64'h0) return 32'h0000_0013;
        if (a == 64'h4) return 32'h0050_0093;
        return a[31:0] ^ 32'hC0DE_0000;
    endfunction

    // Synchronous ROM: data for the address presented before the edge.
    always @(posedge clk) im_dout <= rom_word(im_addr);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard of expected PCs in delivery order.
    logic [63:0] exp_q [$];
    logic [63:0] next_pc;

    function automatic void refill();
        while (exp_q.size() < 16) begin
            exp_q.push_back(next_pc);
            next_pc = next_pc + 64'd4;
        end
    endfunction

    function automatic void redirect(input logic [63:0] pc);
        exp_q.delete();
        next_pc = pc & ~64'h3;
        refill();
    endfunction

    // Monitor: handshake comparison, stall stability, occupancy bound.
    logic        prev_stall = 1'b0;
    logic [63:0] prev_pc;
    logic [31:0] prev_instr;

    always @(negedge clk) begin
        if (reset) begin
            check("count_bound", 64'(count <= 3'(DEPTH)), 64'd1);
            if (prev_stall) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_pc", out_pc, prev_pc);
                check("stall_instr", 64'(out_instr), 64'(prev_instr));
            end
            if (out_valid && out_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    check("sb_empty", 64'(exp_q.size()), 64'd1);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    check("sb_pc", out_pc, e);
                    check("sb_instr", 64'(out_instr), 64'(rom_word(e)));
                    pops++;
                    refill();
                end
            end
            prev_stall = out_valid && !out_ready && !flush;
            prev_pc    = out_pc;
            prev_instr = out_instr;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // First instruction must reach the head exactly two edges after a redirect.
    task automatic expect_first(input logic [63:0] pc);
        tick();
        check("lat_valid_e1", 64'(out_valid), 64'd0);
        tick();
        check("lat_valid_e2", 64'(out_valid), 64'd1);
        check("lat_pc", out_pc, pc);
    endtask

    task automatic do_flush(input logic [63:0] pc);
        flush    = 1'b1;
        flush_pc = pc;
        redirect(pc);
        #1;
        check("flush_im_req", 64'(im_req), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_im_req"}, 64'(im_req), 64'd0);
        check({tag, "_count"}, 64'(count), 64'd0);
        check({tag, "_pc"}, out_pc, 64'd0);
        check({tag, "_instr"}, 64'(out_instr), 64'd0);
    endtask

    initial begin
        bit found;
        reset     = 1'b0;
        flush     = 1'b0;
        flush_pc  = 64'h0;
        out_ready = 1'b1;
        redirect(RESET_PC);
        #2;
        check_reset_outputs("rst");
        check("rst_im_addr", im_addr, RESET_PC);
        tick();
        tick();

        // Reset release with sustained 1/cycle throughput.
        reset = 1'b1;
        redirect(RESET_PC);
        expect_first(64'h0);
        check("first_instr", 64'(out_instr), 64'h13);
        tick();
        check("second_pc", out_pc, 64'h4);
        check("second_instr", 64'(out_instr), 64'h0050_0093);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("throughput", 64'(out_valid), 64'd1);
        end

        // Stall from reset: fill, stop fetching, then drain without gaps.
        reset     = 1'b0;
        out_ready = 1'b0;
        tick();
        reset = 1'b1;
        redirect(RESET_PC);
        repeat (8) tick();
        check("stall_count", 64'(count), 64'd4);
        check("stall_im_req", 64'(im_req), 64'd0);
        check("stall_head", out_pc, 64'h0);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("no_gap", 64'(out_valid), 64'd1);
        end
        check("steady_count", 64'(count), 64'd2);

        // Fill with 8..20, then flush to 0x100.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        redirect(RESET_PC);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (out_valid && out_pc == 64'h8) begin
                out_ready = 1'b0;
                found     = 1'b1;
            end
        end
        check("reach_pc8", 64'(found), 64'd1);
        repeat (6) tick();
        check("fill_count", 64'(count), 64'd4);
        check("fill_head", out_pc, 64'h8);
        do_flush(64'h100);
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        tick();
        check("flush_lat_e1", 64'(out_valid), 64'd0);
        tick();
        check("flush_lat_e2", 64'(out_valid), 64'd1);
        check("flush_pc100", out_pc, 64'h100);
        repeat (4) tick();

        // Misaligned target is word-aligned.
        do_flush(64'h103);
        expect_first(64'h100);
        repeat (3) tick();

        // Back-to-back flushes: last wins.
        flush    = 1'b1;
        flush_pc = 64'h200;
        redirect(64'h200);
        tick();
        do_flush(64'h300);
        expect_first(64'h300);
        repeat (3) tick();

        // Fetch PC wraps at 2^64.
        do_flush(64'hFFFF_FFFF_FFFF_FFF8);
        expect_first(64'hFFFF_FFFF_FFFF_FFF8);
        repeat (6) tick();

        // Asynchronous reset mid-cycle with count=3.
        out_ready = 1'b0;
        do_flush(64'h400);
        repeat (4) tick();
        check("pre_rst_count", 64'(count), 64'd3);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        tick();
        tick();
        reset     = 1'b1;
        out_ready = 1'b1;
        redirect(RESET_PC);
        expect_first(RESET_PC);

        // Randomized ready toggling and occasional flushes.
        for (int i = 0; i < 400; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) begin
                logic [63:0] pc;
                pc = {32'($urandom), 32'($urandom)};
                flush    = 1'b1;
                flush_pc = pc;
                redirect(pc);
            end else begin
                flush = 1'b0;
            end
            tick();
        end
        flush = 1'b0;
        repeat (4) tick();
        check("deliveries", 64'(pops > 150), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
